fpu_wb_stage: RTL and testbench

- Writeback/retire stage directly downstream of the FP multiply/add datapath.
- Accepts results from both result paths:
  - multiply path: valid combinationally in the issue cycle.
  - add/sub/FMA path: valid one cycle after issue, through the datapath's internal non-stallable pipeline register.
- Applies overflow saturation, generates RISC-V fflags, and buffers results in program order into a small dual-write FIFO drained by the register-file writeback port (valid/ready).
- Throttles upstream issue so that a result is never dropped.

---
 rtl/fpu_wb_stage.sv | 158 +++++++++++++++
 tb/tb_fpu_wb_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_wb_stage.sv
// FP writeback stage: saturates overflow, builds fflags, queues mul/add results in issue order (FPU_WB_FLUSH_EN adds flush_i).
// Latency: multiply enqueues in its issue cycle, add one cycle later; an entry shows on wb_* the cycle after it is written.
// Backpressure: issue_ready_o depends on registers only and reserves room for a pending add plus a new multiply.
module fpu_wb_stage #(
  parameter int DEPTH = 4,
  parameter int RD_W  = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic            issue_unit_i,
  input  logic [RD_W-1:0] issue_rd_i,
  input  logic [31:0]     mul_result_i,
  input  logic            mul_overflow_i,
  input  logic [31:0]     alu_result_i,
  input  logic            alu_overflow_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [RD_W-1:0] wb_rd_o,
  output logic [31:0]     wb_data_o,
  output logic [4:0]      wb_fflags_o,
  output logic [4:0]      fflags_acc_o,
  input  logic            fflags_clr_i
`ifdef FPU_WB_FLUSH_EN
  ,
  input  logic            flush_i
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LAST_I = DEPTH - 1;
  localparam logic [PW-1:0] LAST_PTR = LAST_I[PW-1:0];
  localparam logic [CW:0]   DEPTH_C  = DEPTH[CW:0];

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
    logic [4:0]      flags;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW:0]     count_sum;
  logic [CW:0]     occ;
  logic            alu_pend_valid_q, alu_pend_valid_d;
  logic [RD_W-1:0] alu_pend_rd_q, alu_pend_rd_d;
  logic [4:0]      fflags_acc_q, fflags_acc_d;
  logic            iss, push_alu, push_mul, pop, flush;
  entry_t          head;

  // Overflow saturates to infinity of the same sign and raises OF|NX.
  function automatic entry_t form_entry(input logic [RD_W-1:0] rd,
                                        input logic [31:0] res,
                                        input logic ovf);
    entry_t e;
    e.rd    = rd;
    e.data  = ovf ? {res[31], 8'hFF, 23'd0} : res;
    e.flags = ovf ? 5'b00101 : 5'b00000;
    return e;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

`ifdef FPU_WB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign occ           = {1'b0, count_q} + {{CW{1'b0}}, alu_pend_valid_q};
  assign issue_ready_o = occ < DEPTH_C;
  assign iss           = issue_valid_i & issue_ready_o;
  assign push_alu      = alu_pend_valid_q;
  assign push_mul      = iss & ~issue_unit_i;

  assign head         = mem_q[rptr_q];
  assign wb_valid_o   = (count_q != '0);
  assign wb_rd_o      = wb_valid_o ? head.rd    : '0;
  assign wb_data_o    = wb_valid_o ? head.data  : '0;
  assign wb_fflags_o  = wb_valid_o ? head.flags : '0;
  assign fflags_acc_o = fflags_acc_q;
  assign pop          = wb_valid_o & wb_ready_i & ~flush;

  always_comb begin
    mem_d            = mem_q;
    wptr_d           = wptr_q;
    rptr_d           = rptr_q;
    alu_pend_valid_d = iss & issue_unit_i;
    alu_pend_rd_d    = (iss & issue_unit_i) ? issue_rd_i : alu_pend_rd_q;
    fflags_acc_d     = fflags_acc_q;

    // The older add result takes wptr so the multiply lands behind it.
    if (push_alu) begin
      mem_d[wptr_q] = form_entry(alu_pend_rd_q, alu_result_i, alu_overflow_i);
      wptr_d        = ptr_inc(wptr_d);
    end
    if (push_mul) begin
      mem_d[wptr_d] = form_entry(issue_rd_i, mul_result_i, mul_overflow_i);
      wptr_d        = ptr_inc(wptr_d);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end

    count_sum = {1'b0, count_q} + {{CW{1'b0}}, push_alu} + {{CW{1'b0}}, push_mul}
              - {{CW{1'b0}}, pop};
    count_d   = count_sum[CW-1:0];

    if (pop) begin
      fflags_acc_d = (fflags_clr_i ? 5'b00000 : fflags_acc_q) | wb_fflags_o;
    end else if (fflags_clr_i) begin
      fflags_acc_d = '0;
    end

    if (flush) begin
      count_d          = '0;
      wptr_d           = '0;
      rptr_d           = '0;
      alu_pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q          <= '0;
      wptr_q           <= '0;
      rptr_q           <= '0;
      alu_pend_valid_q <= 1'b0;
      alu_pend_rd_q    <= '0;
      fflags_acc_q     <= '0;
    end else begin
      count_q          <= count_d;
      wptr_q           <= wptr_d;
      rptr_q           <= rptr_d;
      alu_pend_valid_q <= alu_pend_valid_d;
      alu_pend_rd_q    <= alu_pend_rd_d;
      fflags_acc_q     <= fflags_acc_d;
    end
  end

  // Storage needs no reset: outputs are gated by count while empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (count_sum <= DEPTH_C);
    end
  end

endmodule

// File: tb/tb_fpu_wb_stage.sv
// Randomized scoreboard bench for fpu_wb_stage; results are expected to retire in issue order.
module tb_fpu_wb_stage;
  localparam int DEPTH = 4;
  localparam int RD_W  = 5;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            issue_valid_i = 1'b0;
  logic            issue_ready_o;
  logic            issue_unit_i = 1'b0;
  logic [RD_W-1:0] issue_rd_i = '0;
  logic [31:0]     mul_result_i = '0;
  logic            mul_overflow_i = 1'b0;
  logic [31:0]     alu_result_i = '0;
  logic            alu_overflow_i = 1'b0;
  logic            wb_valid_o;
  logic            wb_ready_i = 1'b0;
  logic [RD_W-1:0] wb_rd_o;
  logic [31:0]     wb_data_o;
  logic [4:0]      wb_fflags_o;
  logic [4:0]      fflags_acc_o;
  logic            fflags_clr_i = 1'b0;
`ifdef FPU_WB_FLUSH_EN
  logic            flush_i = 1'b0;
`endif

  always #5 clk = ~clk;

  fpu_wb_stage #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_unit_i(issue_unit_i), .issue_rd_i(issue_rd_i),
    .mul_result_i(mul_result_i), .mul_overflow_i(mul_overflow_i),
    .alu_result_i(alu_result_i), .alu_overflow_i(alu_overflow_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_fflags_o(wb_fflags_o),
    .fflags_acc_o(fflags_acc_o), .fflags_clr_i(fflags_clr_i)
`ifdef FPU_WB_FLUSH_EN
    , .flush_i(flush_i)
`endif
  );

  typedef struct {
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
    logic [4:0]      flags;
    int              avail;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [4:0]  acc_exp = '0;
  logic [31:0] alu_next = '0;
  logic        alu_next_ov = 1'b0;
  bit          alu_due = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Every accepted op retires in issue order; a saturated result is a signed infinity.
  function automatic exp_t model(input logic [RD_W-1:0] rd, input logic [31:0] res,
                                 input bit ov, input int avail);
    exp_t e;
    e.rd    = rd;
    e.avail = avail;
    if (ov) begin
      e.data  = res[31] ? 32'hFF80_0000 : 32'h7F80_0000;
      e.flags = 5'b00101;
    end else begin
      e.data  = res;
      e.flags = 5'b00000;
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    bit   ev;
    bit   fl;
    exp_t h;
    fl = 1'b0;
`ifdef FPU_WB_FLUSH_EN
    fl = flush_i;
`endif
    if (rst_i) begin
      acc_exp = '0;
    end else if (fl) begin
      chk("acc_flush", {59'd0, fflags_acc_o}, {59'd0, acc_exp});
      if (fflags_clr_i) acc_exp = '0;
    end else begin
      chk("fflags_acc", {59'd0, fflags_acc_o}, {59'd0, acc_exp});
      ev = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      chk("wb_valid", {63'd0, wb_valid_o}, {63'd0, ev});
      if (!wb_valid_o)
        chk("empty_zero", {22'd0, wb_rd_o, wb_data_o, wb_fflags_o}, 64'd0);
      if (wb_valid_o && wb_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_retire: got rd=%0d data=%h with nothing outstanding", wb_rd_o, wb_data_o);
        end else begin
          h = exp_q.pop_front();
          chk("retire", {22'd0, wb_rd_o, wb_data_o, wb_fflags_o}, {22'd0, h.rd, h.data, h.flags});
          acc_exp = (fflags_clr_i ? 5'd0 : acc_exp) | h.flags;
        end
      end else if (fflags_clr_i) begin
        acc_exp = '0;
      end
    end
  end

  task automatic drive(input bit v, input bit unit, input logic [RD_W-1:0] rd,
                       input logic [31:0] res, input bit ov, input bit rdy,
                       input bit clr, input bit fl);
    bit mready;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    if (alu_due) begin
      alu_result_i   = alu_next;
      alu_overflow_i = alu_next_ov;
    end else begin
      alu_result_i   = $urandom;
      alu_overflow_i = 1'($urandom_range(0, 1));
    end
    alu_due = 1'b0;
    mready  = exp_q.size() < DEPTH;
    chk("issue_ready", {63'd0, issue_ready_o}, {63'd0, mready});
    issue_valid_i  = v;
    issue_unit_i   = unit;
    issue_rd_i     = rd;
    mul_result_i   = unit ? $urandom : res;
    mul_overflow_i = unit ? 1'($urandom_range(0, 1)) : ov;
    wb_ready_i     = rdy;
    fflags_clr_i   = clr;
`ifdef FPU_WB_FLUSH_EN
    flush_i = fl;
`endif
    if (fl) begin
      exp_q.delete();
    end else if (v && mready) begin
      exp_q.push_back(model(rd, res, ov, unit ? cyc + 2 : cyc + 1));
      if (unit) begin
        alu_due     = 1'b1;
        alu_next    = res;
        alu_next_ov = ov;
      end
    end
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, $urandom, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_i         = 1'b1;
    issue_valid_i = 1'b0;
    wb_ready_i    = 1'b0;
    fflags_clr_i  = 1'b0;
`ifdef FPU_WB_FLUSH_EN
    flush_i = 1'b0;
`endif
    exp_q.delete();
    alu_due = 1'b0;
  endtask

  initial begin
    bit fl;
    repeat (2) @(posedge clk);

    drive(1'b1, 1'b0, 5'd3, 32'h40490FDB, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);

    drive(1'b1, 1'b1, 5'd7, 32'h3F800000, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd9, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);

    drive(1'b1, 1'b0, 5'd4, 32'hC1234567, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);
    drive(1'b0, 1'b0, '0, $urandom, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Fill with the consumer stalled, then offer more issues that must be refused.
    drive(1'b1, 1'b1, 5'd1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'd2, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd3, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd4, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 5'd31, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 8);

    drive(1'b1, 1'b0, 5'd5, $urandom, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 5'(10 + k), $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'd20, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    idle(1'b1, 3);

`ifdef FPU_WB_FLUSH_EN
    drive(1'b1, 1'b0, 5'd6, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);
    drive(1'b1, 1'b0, 5'd21, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd22, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1);
    drive(1'b1, 1'b0, 5'd23, $urandom, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 3);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        fl = 1'b0;
`ifdef FPU_WB_FLUSH_EN
        fl = ($urandom_range(0, 99) == 0);
`endif
        drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 5'($urandom),
              $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 6,
              $urandom_range(0, 15) == 0, fl);
      end
    end

    idle(1'b1, 12);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
